// File: rtl/codeword_pkg.sv
// Shared constants for the code-word detector and its display counter:
// seven-segment encodings, one-cold anode patterns and the detector states.
package codeword_pkg;

    localparam int BCD_W = 4;

    // Active-low segments, bit order g..a
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_0 = 4'b1110;
    localparam logic [3:0] AN_1 = 4'b1101;
    localparam logic [3:0] AN_2 = 4'b1011;
    localparam logic [3:0] AN_3 = 4'b0111;

    typedef enum logic [2:0] {
        DET_IDLE  = 3'd0,
        DET_S1    = 3'd1,
        DET_S2    = 3'd2,
        DET_S3    = 3'd3,
        DET_MATCH = 3'd4
    } det_state_t;

endpackage

// File: rtl/codeword_counter_if.sv
// Connection bundle between the detector side and the counter/display block.
interface codeword_counter_if;
    import codeword_pkg::*;

    logic                   pulse;
    logic                   clear;
    logic [4*BCD_W-1:0]     count_bcd;
    logic                   overflow;
    logic [3:0]             an;
    logic [6:0]             seg;

    modport master (output pulse, output clear,
                    input count_bcd, input overflow, input an, input seg);
    modport slave  (input pulse, input clear,
                    output count_bcd, output overflow, output an, output seg);
endinterface

// File: rtl/bcd_digit.sv
// One decade counter stage; carries out combinationally when at 9 with carry-in.
module bcd_digit
    import codeword_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             cin,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    logic [BCD_W-1:0] r_q;

    assign q    = r_q;
    assign cout = cin & (r_q == 4'd9);

    // Decade state: clear wins over carry-in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 4'd0;
        end else if (clear) begin
            r_q <= 4'd0;
        end else if (cin) begin
            r_q <= (r_q == 4'd9) ? 4'd0 : (r_q + 4'd1);
        end else begin
            r_q <= r_q;
        end
    end

endmodule

// File: rtl/codeword_counter.sv
// Counts rising edges of the detector flag in 4-digit BCD with a sticky
// overflow, and scans the count onto a multiplexed seven-segment display.
module codeword_counter
    import codeword_pkg::*;
#(
    parameter int REFRESH_BITS = 16
)(
    input  logic               clk,
    input  logic               reset,
    codeword_counter_if.slave  bus
);

    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic                    r_pulse_d;
    logic                    w_inc;
    logic [BCD_W-1:0]        w_q [4];
    logic [4:0]              w_carry;
    logic                    r_overflow;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [1:0]              r_digit_sel;
    logic [BCD_W-1:0]        w_digit;
    logic [3:0]              r_an;
    logic [6:0]              r_seg;

    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    assign w_inc      = bus.pulse & ~r_pulse_d;
    assign w_carry[0] = w_inc;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clear (bus.clear),
            .cin   (w_carry[g]),
            .q     (w_q[g]),
            .cout  (w_carry[g+1])
        );
    end

    assign bus.count_bcd = {w_q[3], w_q[2], w_q[1], w_q[0]};
    assign bus.overflow  = r_overflow;
    assign bus.an        = r_an;
    assign bus.seg       = r_seg;

    // Pulse history tracks the input even while clear is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse_d <= 1'b0;
        end else begin
            r_pulse_d <= bus.pulse;
        end
    end

    // Sticky wrap flag, set by carry out of the thousands digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_overflow <= 1'b0;
        end else if (w_carry[4]) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    // Scan timebase: digit advances when refresh rolls over to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh   <= '0;
            r_digit_sel <= 2'd0;
        end else begin
            r_refresh <= r_refresh + REFRESH_ONE;
            if (&r_refresh) begin
                r_digit_sel <= r_digit_sel + 2'd1;
            end else begin
                r_digit_sel <= r_digit_sel;
            end
        end
    end

    // Selected digit mux
    always_comb begin
        w_digit = w_q[0];
        case (r_digit_sel)
            2'd0:    w_digit = w_q[0];
            2'd1:    w_digit = w_q[1];
            2'd2:    w_digit = w_q[2];
            2'd3:    w_digit = w_q[3];
            default: w_digit = w_q[0];
        endcase
    end

    // Registered display drive keeps anodes and segments glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= AN_0;
            r_seg <= SEG_0;
        end else begin
            case (r_digit_sel)
                2'd0:    r_an <= AN_0;
                2'd1:    r_an <= AN_1;
                2'd2:    r_an <= AN_2;
                2'd3:    r_an <= AN_3;
                default: r_an <= AN_0;
            endcase
            r_seg <= seg_decode(w_digit);
        end
    end

endmodule

// File: tb/tb_codeword_counter.sv
// Directed bench for codeword_counter with a decimal-arithmetic reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_codeword_counter;

    localparam int RB     = 2;
    localparam int PERIOD = 1 << RB;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    codeword_counter_if bus();

    codeword_counter #(.REFRESH_BITS(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: plain decimal count and cycle-based scan position
    int         m_count;
    bit         m_ov;
    bit         m_pd;
    int         m_cyc;
    int         m_sel;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic [6:0] segtab [10];

    initial begin
        segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
        segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
        segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
        segtab[9] = 7'b0010000;
    end

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int dec_digit(input int v, input int pos);
        int d;
        d = v;
        for (int i = 0; i < pos; i++) d = d / 10;
        return d % 10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge, display outputs computed from pre-edge state
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_count = 0; m_ov = 1'b0; m_pd = 1'b0; m_cyc = 0; m_sel = 0;
            m_an = 4'b1110; m_seg = 7'b1000000;
        end else begin
            m_an  = ~(4'b0001 << m_sel);
            m_seg = segtab[dec_digit(m_count, m_sel)];
            if (bus.clear) begin
                m_count = 0; m_ov = 1'b0;
            end else if (bus.pulse && !m_pd) begin
                if (m_count == 9999) begin
                    m_count = 0; m_ov = 1'b1;
                end else begin
                    m_count = m_count + 1;
                end
            end
            m_pd  = bus.pulse;
            m_cyc = m_cyc + 1;
            if (m_cyc % PERIOD == 0) m_sel = (m_sel + 1) % 4;
        end
    end

    // Per-cycle compare against the model
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            chk("model_count", bus.count_bcd, to_bcd(m_count));
            chk("model_ovf",   bus.overflow,  m_ov);
            chk("model_an",    bus.an,        m_an);
            chk("model_seg",   bus.seg,       m_seg);
        end
    end

    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.pulse = 1'b1;
            @(negedge clk) bus.pulse = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic do_clear();
        @(negedge clk) bus.clear = 1'b1;
        @(negedge clk) bus.clear = 1'b0;
    endtask

    // Align to the negedge just after an switches onto the units digit
    task automatic sync_slot0();
        int k;
        k = 0;
        while (bus.an == 4'b1110 && k < 40) begin @(negedge clk); k++; end
        while (bus.an != 4'b1110 && k < 40) begin @(negedge clk); k++; end
        chk("slot_sync_bound", 32'(k < 40), 32'd1);
    endtask

    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];

    initial begin
        reset = 1'b1; bus.pulse = 1'b0; bus.clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", bus.count_bcd, 16'h0000);
        chk("rst_ovf",   bus.overflow,  1'b0);
        chk("rst_an",    bus.an,        4'b1110);
        chk("rst_seg",   bus.seg,       7'b1000000);
        reset = 1'b0;

        // Reset mid-count
        pulses(42, 1);
        chk("pre_reset_42", bus.count_bcd, 16'h0042);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("async_rst_count", bus.count_bcd, 16'h0000);
        chk("async_rst_an",    bus.an,        4'b1110);
        chk("async_rst_seg",   bus.seg,       7'b1000000);
        @(negedge clk) reset = 1'b0;
        pulses(1, 1);
        chk("post_reset_1", bus.count_bcd, 16'h0001);

        // Spaced pulses then one wide pulse
        do_clear();
        pulses(12, 5);
        chk("twelve", bus.count_bcd, 16'h0012);
        @(negedge clk) bus.pulse = 1'b1;
        repeat (10) @(negedge clk);
        bus.pulse = 1'b0;
        @(negedge clk);
        chk("wide_pulse", bus.count_bcd, 16'h0013);

        // Clear coincident with a pulse rising edge
        do_clear();
        pulses(457, 1);
        chk("at_0457", bus.count_bcd, 16'h0457);
        @(negedge clk) begin bus.clear = 1'b1; bus.pulse = 1'b1; end
        @(negedge clk) bus.clear = 1'b0;
        chk("clr_pulse_count", bus.count_bcd, 16'h0000);
        chk("clr_pulse_ovf",   bus.overflow,  1'b0);
        @(negedge clk);
        chk("clr_pulse_held",  bus.count_bcd, 16'h0000);
        bus.pulse = 1'b0;
        @(negedge clk);

        // Wrap and sticky overflow
        do_clear();
        pulses(9999, 1);
        chk("at_9999",     bus.count_bcd, 16'h9999);
        chk("at_9999_ovf", bus.overflow,  1'b0);
        pulses(1, 1);
        chk("wrap_count", bus.count_bcd, 16'h0000);
        chk("wrap_ovf",   bus.overflow,  1'b1);
        pulses(1, 1);
        chk("after_wrap_count", bus.count_bcd, 16'h0001);
        chk("after_wrap_ovf",   bus.overflow,  1'b1);

        // Display scan of 1905
        do_clear();
        pulses(1905, 1);
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        exp_seg[0] = 7'b0010010; exp_seg[1] = 7'b1000000;
        exp_seg[2] = 7'b0010000; exp_seg[3] = 7'b1111001;
        sync_slot0();
        for (int i = 0; i < 16; i++) begin
            chk("scan_an",  bus.an,  exp_an[i / 4]);
            chk("scan_seg", bus.seg, exp_seg[i / 4]);
            @(negedge clk);
        end

        // Display latency on the selected digit
        do_clear();
        pulses(4, 1);
        sync_slot0();
        chk("lat_seg_before", bus.seg, 7'b0011001);
        bus.pulse = 1'b1;
        @(negedge clk) bus.pulse = 1'b0;
        chk("lat_seg_1clk", bus.seg, 7'b0011001);
        @(negedge clk);
        chk("lat_seg_2clk", bus.seg, 7'b0010010);
        chk("lat_an_2clk",  bus.an,  4'b1110);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
